// File: rtl/sat_bin_loader_if.sv
// ============================================================================
//  Module      : sat_bin_loader_if
//  Description : Bundles the host stream, the sat_bin external RAM load port,
//                the sat_bin control/result signals and the loader status.
//                master = loader side, slave = host / sat_bin side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sat_bin_loader_if #(
  parameter int WIDTH_CLAUSES      = 16,
  parameter int WIDTH_VAR          = 12,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int ADDR_WIDTH_VAR     = 9
) ();

  // host configuration and word stream
  logic                          load_start_i;
  logic [WIDTH_CLAUSES-1:0]      nb_i;
  logic [WIDTH_VAR-1:0]          nv_i;
  logic [ADDR_WIDTH_CLAUSES-1:0] n_words_i;
  logic                          data_valid_i;
  logic [WIDTH_CLAUSES-1:0]      data_i;
  logic                          data_ready_o;

  // sat_bin external RAM load port
  logic                          apply_ex_o;
  logic                          ram_we_c_ex_o;
  logic [WIDTH_CLAUSES-1:0]      ram_din_c_ex_o;
  logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_ex_o;
  logic                          ram_we_v_ex_o;
  logic [WIDTH_VAR-1:0]          ram_din_v_ex_o;
  logic [ADDR_WIDTH_VAR-1:0]     ram_addr_v_ex_o;

  // sat_bin control and result
  logic                          start_o;
  logic                          bin_info_en_o;
  logic [WIDTH_CLAUSES-1:0]      nb_all_o;
  logic [WIDTH_VAR-1:0]          nv_all_o;
  logic                          sb_done_i;
  logic                          global_sat_i;
  logic                          global_unsat_i;

  // loader status
  logic                          busy_o;
  logic                          done_o;
  logic                          sat_o;
  logic                          unsat_o;

  modport master (
    input  load_start_i, nb_i, nv_i, n_words_i, data_valid_i, data_i,
    input  sb_done_i, global_sat_i, global_unsat_i,
    output data_ready_o, apply_ex_o,
    output ram_we_c_ex_o, ram_din_c_ex_o, ram_addr_c_ex_o,
    output ram_we_v_ex_o, ram_din_v_ex_o, ram_addr_v_ex_o,
    output start_o, bin_info_en_o, nb_all_o, nv_all_o,
    output busy_o, done_o, sat_o, unsat_o
  );

  modport slave (
    output load_start_i, nb_i, nv_i, n_words_i, data_valid_i, data_i,
    output sb_done_i, global_sat_i, global_unsat_i,
    input  data_ready_o, apply_ex_o,
    input  ram_we_c_ex_o, ram_din_c_ex_o, ram_addr_c_ex_o,
    input  ram_we_v_ex_o, ram_din_v_ex_o, ram_addr_v_ex_o,
    input  start_o, bin_info_en_o, nb_all_o, nv_all_o,
    input  busy_o, done_o, sat_o, unsat_o
  );

endinterface

`default_nettype wire

// File: rtl/sat_bin_loader.sv
// ============================================================================
//  Module      : sat_bin_loader
//  Description : Host-side master for the sat_bin external load port. Writes
//                the clause-bin RAM then the var-bin RAM (addresses 1..N) from
//                a valid/ready word stream, pulses start with the bin info,
//                waits for sat_bin done and latches the SAT/UNSAT result.
//                Interface parameters must match the module parameters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_bin_loader #(
  parameter int WIDTH_CLAUSES      = 16,
  parameter int WIDTH_VAR          = 12,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int ADDR_WIDTH_VAR     = 9
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sat_bin_loader_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_C  = 3'd1;
  localparam logic [2:0] S_GAP_C = 3'd2;
  localparam logic [2:0] S_WR_V  = 3'd3;
  localparam logic [2:0] S_GAP_V = 3'd4;
  localparam logic [2:0] S_START = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]                    state;
  logic [WIDTH_CLAUSES-1:0]      nb_cap;
  logic [WIDTH_VAR-1:0]          nv_cap;
  logic [ADDR_WIDTH_CLAUSES-1:0] nw_cap;
  logic [ADDR_WIDTH_CLAUSES-1:0] word_cnt;
  logic                          wait_first;

  logic                          we_c;
  logic [WIDTH_CLAUSES-1:0]      din_c;
  logic [ADDR_WIDTH_CLAUSES-1:0] addr_c;
  logic                          we_v;
  logic [WIDTH_VAR-1:0]          din_v;
  logic [ADDR_WIDTH_VAR-1:0]     addr_v;
  logic                          sat_res;
  logic                          unsat_res;

  logic                          in_wr_c;
  logic                          in_wr_v;
  logic                          accept;
  logic [ADDR_WIDTH_CLAUSES-1:0] cnt_inc;
  logic                          last_word;

  assign in_wr_c   = (state == S_WR_C);
  assign in_wr_v   = (state == S_WR_V);
  assign accept    = bus.data_valid_i && (in_wr_c || in_wr_v);
  assign cnt_inc   = word_cnt + 1'b1;
  assign last_word = (cnt_inc == nw_cap);

  // State-decoded control outputs; all are low in IDLE, which covers reset
  always_comb begin
    bus.data_ready_o  = in_wr_c || in_wr_v;
    bus.apply_ex_o    = (state == S_WR_C) || (state == S_GAP_C) ||
                        (state == S_WR_V) || (state == S_GAP_V);
    bus.start_o       = (state == S_START);
    bus.bin_info_en_o = (state == S_START);
    bus.busy_o        = (state != S_IDLE);
    bus.done_o        = (state == S_DONE);
  end

  assign bus.ram_we_c_ex_o   = we_c;
  assign bus.ram_din_c_ex_o  = din_c;
  assign bus.ram_addr_c_ex_o = addr_c;
  assign bus.ram_we_v_ex_o   = we_v;
  assign bus.ram_din_v_ex_o  = din_v;
  assign bus.ram_addr_v_ex_o = addr_v;
  assign bus.nb_all_o        = nb_cap;
  assign bus.nv_all_o        = nv_cap;
  assign bus.sat_o           = sat_res;
  assign bus.unsat_o         = unsat_res;

  // Sequencer: load capture, word counting and phase transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      nb_cap     <= '0;
      nv_cap     <= '0;
      nw_cap     <= '0;
      word_cnt   <= '0;
      wait_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load_start_i) begin
            nb_cap   <= bus.nb_i;
            nv_cap   <= bus.nv_i;
            nw_cap   <= bus.n_words_i;
            word_cnt <= '0;
            // an empty load skips straight to the gap cycles
            state    <= (bus.n_words_i == '0) ? S_GAP_C : S_WR_C;
          end
        end
        S_WR_C: begin
          if (accept) begin
            word_cnt <= last_word ? '0 : cnt_inc;
            if (last_word) state <= S_GAP_C;
          end
        end
        S_GAP_C: begin
          state <= (nw_cap == '0) ? S_GAP_V : S_WR_V;
        end
        S_WR_V: begin
          if (accept) begin
            word_cnt <= last_word ? '0 : cnt_inc;
            if (last_word) state <= S_GAP_V;
          end
        end
        S_GAP_V: begin
          state <= S_START;
        end
        S_START: begin
          wait_first <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // the cycle right after start never looks at sb_done_i
          wait_first <= 1'b0;
          if (!wait_first && bus.sb_done_i) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM write port: one-cycle write pulse the cycle after each accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      we_c   <= 1'b0;
      din_c  <= '0;
      addr_c <= '0;
      we_v   <= 1'b0;
      din_v  <= '0;
      addr_v <= '0;
    end else begin
      we_c <= accept && in_wr_c;
      we_v <= accept && in_wr_v;
      // address/data hold their last value while the write enable is low
      if (accept && in_wr_c) begin
        din_c  <= bus.data_i;
        addr_c <= cnt_inc;
      end
      if (accept && in_wr_v) begin
        din_v  <= bus.data_i[WIDTH_VAR-1:0];
        addr_v <= ADDR_WIDTH_VAR'(cnt_inc);
      end
    end
  end

  // Result latch: cleared by a new load, captured when sat_bin reports done
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_res   <= 1'b0;
      unsat_res <= 1'b0;
    end else if (state == S_IDLE && bus.load_start_i) begin
      sat_res   <= 1'b0;
      unsat_res <= 1'b0;
    end else if (state == S_WAIT && !wait_first && bus.sb_done_i) begin
      sat_res   <= bus.global_sat_i;
      unsat_res <= bus.global_unsat_i;
    end
  end

endmodule

`default_nettype wire
